// File: rtl/trace_pkg.sv
// Shared types and helpers for the trace buffer: FSM state encoding, mode bit
// position and pointer-width helper.
package trace_pkg;

  typedef enum logic [1:0] {IDLE, TRACE, FETCH, DRAIN} tb_state_t;

  localparam int TB_MODE_LINEAR = 0;

  function automatic int tb_ptr_w(input int size);
    return $clog2(size);
  endfunction

endpackage

// File: rtl/tb_mem.sv
// Trace storage: simple dual-port RAM with one write port and a registered read
// port. No reset so it maps onto block RAM.
module tb_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 256,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/trace_buffer.sv
// Circular/linear trace capture of packed vectors, drained oldest-first as a
// valid/ready element stream.
//   state | meaning
//   IDLE  | config bytes accepted, waiting for tracing
//   TRACE | capturing vectors on valid_in
//   FETCH | reading the oldest vector into the RAM output register
//   DRAIN | streaming elements of the held vector
module trace_buffer
  import trace_pkg::*;
#(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int TB_SIZE            = 8,
  parameter int PERSONAL_CONFIG_ID = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tracing,
  input  logic                            valid_in,
  input  logic [N*DATA_WIDTH-1:0]         vector_in,
  input  logic [7:0]                      configId,
  input  logic [7:0]                      configData,
  input  logic                            rd_ready,
  output logic                            rd_valid,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            rd_last,
  output logic                            wrapped,
  output logic                            overflow,
  output logic [tb_ptr_w(TB_SIZE):0]      entries
);

  localparam int PW = tb_ptr_w(TB_SIZE);
  localparam int EW = PW + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int VW = N * DATA_WIDTH;

  tb_state_t     state, state_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt, rd_base, rd_base_nxt, wr_addr;
  logic [EW-1:0] entries_nxt;
  logic          wrapped_nxt, overflow_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [7:0]    mode, mode_nxt, byte_cnt, byte_cnt_nxt;
  logic          wr_en, rd_en, clear, capture;
  logic [VW-1:0] hold;
  logic          unused_mode;

  assign unused_mode = ^mode;

  tb_mem #(.DEPTH(TB_SIZE), .WIDTH(VW), .AW(PW)) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (vector_in),
    .rd_en   (rd_en),
    .rd_addr (rd_base),
    .rd_data (hold)
  );

  assign rd_valid = (state == DRAIN);
  assign rd_last  = rd_valid && (entries == EW'(1)) && (idx == IW'(N - 1));
  assign rd_data  = rd_valid ? hold[idx*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    rd_base_nxt  = rd_base;
    entries_nxt  = entries;
    wrapped_nxt  = wrapped;
    overflow_nxt = overflow;
    idx_nxt      = idx;
    mode_nxt     = mode;
    byte_cnt_nxt = byte_cnt;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    clear        = 1'b0;
    capture      = 1'b0;
    wr_addr      = '0;
    case (state)
      IDLE: begin
        if (tracing) begin
          clear   = 1'b1;
          capture = 1'b1;
        end else if (configId == 8'(PERSONAL_CONFIG_ID)) begin
          if (byte_cnt == 8'd0) mode_nxt = configData;
          if (byte_cnt != 8'hFF) byte_cnt_nxt = byte_cnt + 8'd1;
        end else begin
          byte_cnt_nxt = 8'd0;
        end
      end
      TRACE: begin
        if (tracing) capture = 1'b1;
        else state_nxt = (entries != '0) ? FETCH : IDLE;
      end
      FETCH: begin
        if (tracing) begin
          clear = 1'b1;
        end else begin
          rd_en     = 1'b1;
          idx_nxt   = '0;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (tracing) begin
          clear = 1'b1;
        end else if (rd_ready) begin
          if (idx == IW'(N - 1)) begin
            idx_nxt     = '0;
            rd_base_nxt = rd_base + 1'b1;
            entries_nxt = entries - 1'b1;
            state_nxt   = (entries == EW'(1)) ? IDLE : FETCH;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (clear) begin
      state_nxt    = TRACE;
      wr_ptr_nxt   = '0;
      rd_base_nxt  = '0;
      entries_nxt  = '0;
      wrapped_nxt  = 1'b0;
      overflow_nxt = 1'b0;
      idx_nxt      = '0;
    end

    // capture sees the post-clear pointers so the first vector of a trace lands at 0
    wr_addr = wr_ptr_nxt;
    if (capture && valid_in) begin
      if (entries_nxt != EW'(TB_SIZE)) begin
        wr_en       = 1'b1;
        wr_ptr_nxt  = wr_ptr_nxt + 1'b1;
        entries_nxt = entries_nxt + 1'b1;
      end else if (!mode[TB_MODE_LINEAR]) begin
        wr_en       = 1'b1;
        wr_ptr_nxt  = wr_ptr_nxt + 1'b1;
        rd_base_nxt = rd_base_nxt + 1'b1;
        wrapped_nxt = 1'b1;
      end else begin
        overflow_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_base  <= '0;
      entries  <= '0;
      wrapped  <= 1'b0;
      overflow <= 1'b0;
      idx      <= '0;
      mode     <= 8'd0;
      byte_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      rd_base  <= rd_base_nxt;
      entries  <= entries_nxt;
      wrapped  <= wrapped_nxt;
      overflow <= overflow_nxt;
      idx      <= idx_nxt;
      mode     <= mode_nxt;
      byte_cnt <= byte_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_trace_buffer.sv
// Randomized bench for trace_buffer against a queue-based reference model of
// the stored vectors.
module tb_trace_buffer;

  localparam int N   = 8;
  localparam int DW  = 32;
  localparam int TBS = 8;
  localparam int PID = 0;
  localparam int VW  = N * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tracing, valid_in, rd_ready;
  logic [VW-1:0] vector_in;
  logic [7:0]    configId, configData;
  logic          rd_valid, rd_last, wrapped, overflow;
  logic [DW-1:0] rd_data;
  logic [3:0]    entries;

  int total = 0;
  int bad   = 0;

  logic [VW-1:0] q[$];
  bit            linear, m_wrapped, m_overflow;

  trace_buffer #(.N(N), .DATA_WIDTH(DW), .TB_SIZE(TBS), .PERSONAL_CONFIG_ID(PID)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tracing    (tracing),
    .valid_in   (valid_in),
    .vector_in  (vector_in),
    .configId   (configId),
    .configData (configData),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .wrapped    (wrapped),
    .overflow   (overflow),
    .entries    (entries)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] mkvec(input bit pat, input int v);
    logic [VW-1:0] r;
    for (int j = 0; j < N; j++)
      r[j*DW +: DW] = pat ? DW'(256 * v + j) : DW'($urandom);
    return r;
  endfunction

  task automatic m_push(input logic [VW-1:0] v);
    if (q.size() < TBS) q.push_back(v);
    else if (!linear) begin
      void'(q.pop_front());
      q.push_back(v);
      m_wrapped = 1'b1;
    end else m_overflow = 1'b1;
  endtask

  task automatic m_clear();
    q.delete();
    m_wrapped  = 1'b0;
    m_overflow = 1'b0;
  endtask

  task automatic config_mode(input logic [7:0] b0, input logic [7:0] b1);
    configId   = 8'(PID);
    configData = b0;
    step();
    configData = b1;
    step();
    configId   = 8'hFF;
    configData = 8'($urandom);
    step();
    linear = b0[0];
  endtask

  // clr=0 means tracing is already high and the model was cleared by an abort
  task automatic capture(input int nvalid, input bit clr, input bit pat, input int gap, input int min_cyc);
    int v   = 0;
    int cyc = 0;
    if (clr) m_clear();
    tracing = 1'b1;
    while (v < nvalid || cyc < min_cyc) begin
      chk("cap_entries", 64'(entries), 64'(clr && cyc == 0 ? 0 : q.size()));
      valid_in  = (v < nvalid) && ($urandom_range(99) >= gap);
      vector_in = mkvec(pat, v);
      if (valid_in) begin
        m_push(vector_in);
        v++;
      end
      cyc++;
      step();
    end
    tracing   = 1'b0;
    valid_in  = 1'($urandom_range(1));
    vector_in = mkvec(1'b0, 0);
    chk("end_entries", 64'(entries), 64'(q.size()));
    chk("end_wrapped", 64'(wrapped), 64'(m_wrapped));
    chk("end_overflow", 64'(overflow), 64'(m_overflow));
  endtask

  // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random; stop>0 stops after that many elements
  task automatic drain(input int rmode, input int stop, input bit use_reset);
    int  idx = 0, hs = 0, k = 0, idle = 0;
    int  expect_n;
    bit  in_fetch, done = 1'b0, stopped = 1'b0;
    bit  rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [DW-1:0] exp_d;
    expect_n = q.size() * N;
    in_fetch = (q.size() > 0);
    for (int b = 0; b < 1000 && !done; b++) begin
      step();
      if (in_fetch) begin
        chk("fetch_valid", 64'(rd_valid), 64'd0);
        in_fetch = 1'b0;
        rd_ready = 1'($urandom_range(1));
      end else if (q.size() > 0) begin
        exp_d = q[0][idx*DW +: DW];
        chk("drain_valid", 64'(rd_valid), 64'd1);
        chk("drain_data", 64'(rd_data), 64'(exp_d));
        chk("drain_last", 64'(rd_last), 64'(q.size() == 1 && idx == N - 1));
        chk("drain_entries", 64'(entries), 64'(q.size()));
        if (stop > 0 && hs == stop) begin
          if (use_reset) begin
            rst_n = 1'b0;
            #1;
            chk("rst_valid", 64'(rd_valid), 64'd0);
            chk("rst_last", 64'(rd_last), 64'd0);
            chk("rst_data", 64'(rd_data), 64'd0);
            chk("rst_entries", 64'(entries), 64'd0);
            chk("rst_wrapped", 64'(wrapped), 64'd0);
            chk("rst_overflow", 64'(overflow), 64'd0);
            m_clear();
            linear = 1'b0;
            step();
            rst_n = 1'b1;
          end else begin
            tracing  = 1'b1;
            valid_in = 1'b1;
            rd_ready = 1'b1;
            step();
            chk("abort_valid", 64'(rd_valid), 64'd0);
            chk("abort_entries", 64'(entries), 64'd0);
            m_clear();
          end
          stopped = 1'b1;
          done    = 1'b1;
        end else begin
          case (rmode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = rdy_pat[k % 4];
            default: rd_ready = 1'($urandom_range(1));
          endcase
          k++;
          if (rd_ready) begin
            hs++;
            idx++;
            if (idx == N) begin
              idx = 0;
              void'(q.pop_front());
              in_fetch = (q.size() > 0);
            end
          end
        end
      end else begin
        chk("idle_valid", 64'(rd_valid), 64'd0);
        chk("idle_entries", 64'(entries), 64'd0);
        rd_ready = 1'($urandom_range(1));
        idle++;
        if (idle >= 3) done = 1'b1;
      end
    end
    chk("drain_done", 64'(done), 64'd1);
    if (!stopped) chk("elem_count", 64'(hs), 64'(expect_n));
  endtask

  initial begin
    rst_n      = 1'b0;
    tracing    = 1'b0;
    valid_in   = 1'b0;
    rd_ready   = 1'b0;
    vector_in  = '0;
    configId   = 8'hFF;
    configData = 8'h00;
    linear     = 1'b0;
    m_clear();
    #12;
    chk("reset_valid", 64'(rd_valid), 64'd0);
    chk("reset_last", 64'(rd_last), 64'd0);
    chk("reset_data", 64'(rd_data), 64'd0);
    chk("reset_entries", 64'(entries), 64'd0);
    chk("reset_wrapped", 64'(wrapped), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    capture(3, 1'b1, 1'b1, 0, 0);
    drain(0, 0, 1'b0);

    capture(10, 1'b1, 1'b1, 0, 0);
    drain(0, 0, 1'b0);

    config_mode(8'h01, 8'h00);
    capture(10, 1'b1, 1'b1, 0, 0);
    drain(0, 0, 1'b0);

    config_mode(8'h00, 8'h01);
    capture(8, 1'b1, 1'b0, 30, 0);
    drain(1, 0, 1'b0);

    capture(0, 1'b1, 1'b0, 0, 3);
    drain(0, 0, 1'b0);

    capture(3, 1'b1, 1'b1, 0, 0);
    drain(0, 5, 1'b0);
    capture(10, 1'b0, 1'b1, 0, 0);
    drain(2, 0, 1'b0);

    capture(10, 1'b1, 1'b0, 0, 0);
    drain(2, 7, 1'b1);
    capture(4, 1'b1, 1'b0, 20, 0);
    drain(0, 0, 1'b0);

    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(1) == 1) config_mode(8'($urandom), 8'($urandom));
      capture($urandom_range(12), 1'b1, 1'b0, $urandom_range(50), 1);
      drain($urandom_range(2), 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trace_buffer.md
Name: trace_buffer

Overview:
- Sits directly downstream of the data packer and captures its packed N-wide vectors (valid_out/vector_out) into an on-chip circular trace memory while tracing is high.
- When tracing falls, it drains the captured vectors oldest-first as a stream of DATA_WIDTH-bit elements over a valid/ready offload interface.
- It is configured over the shared configId/configData byte bus, like every other instrumentation stage.

Parameters:
- N, 8: elements per vector; must match the packer.
- DATA_WIDTH, 32: bits per element.
- TB_SIZE, 8: depth in vectors; power of two, at least 2.
- PERSONAL_CONFIG_ID, 0: configId value this block responds to.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tracing  in  1  high = capture phase; low = config/drain phase
- valid_in  in  1  vector_in is valid (packer valid_out)
- vector_in  in  DATA_WIDTH x N  packed vector (packer vector_out)
- configId  in  8  config target id
- configData  in  8  config byte
- rd_ready  in  1  offload sink accepts rd_data
- rd_valid  out  1  rd_data valid
- rd_data  out  DATA_WIDTH  drained element
- rd_last  out  1  marks the final element of the drain
- wrapped  out  1  circular mode: at least one vector was overwritten
- overflow  out  1  linear mode: at least one vector was dropped
- entries  out  clog2(TB_SIZE)+1  vectors currently stored

Behaviour:
- Reset (async, rst_n=0):
  - rd_valid, rd_last, wrapped, overflow = 0; entries = 0; rd_data = 0.
  - Pointers = 0; state = IDLE; mode = 0 (circular); byte_counter = 0.
  - Memory contents are don't-care.
- States: IDLE, TRACE, FETCH, DRAIN.
- IDLE:
  - tracing=1 -> TRACE next cycle. Entering TRACE from IDLE clears entries, pointers, wrapped and overflow.
  - A valid_in in the same cycle tracing rises is captured.
  - tracing=0 and configId==PERSONAL_CONFIG_ID: byte_counter increments; byte 0 is latched into mode. mode[0]=1 selects linear; mode[0]=0 selects circular. Other bytes are ignored.
  - configId != PERSONAL_CONFIG_ID resets byte_counter to 0.
- TRACE: on valid_in=1, write vector_in at wr_ptr and increment wr_ptr modulo TB_SIZE.
  - Not full: entries+1.
  - Full, circular: overwrite the oldest vector; rd_base advances by 1; entries stays TB_SIZE; wrapped=1 (sticky).
  - Full, linear: no write, pointers unchanged; overflow=1 (sticky).
  - tracing=0: go to FETCH if entries>0, else IDLE. A valid_in in the cycle tracing is low is ignored.
- FETCH: one-cycle synchronous memory read of the vector at rd_base into a holding register. Element index = 0. Then go to DRAIN.
- DRAIN:
  - rd_valid=1; rd_data = hold[idx]; rd_last=1 only when entries==1 and idx==N-1.
  - rd_data, rd_valid and rd_last are held stable until rd_valid&&rd_ready.
  - On handshake with idx<N-1: idx+1.
  - On handshake with idx==N-1: rd_base+1, entries-1. If entries was 1 -> IDLE with rd_valid=0 next cycle; else -> FETCH.
- Drain latency: tracing falls at edge t -> FETCH at t+1 -> rd_valid=1 at t+2.
- Throughput: one element per cycle within a vector, plus one bubble cycle per vector for FETCH.
- valid_in is ignored in FETCH and DRAIN.
- tracing rising during FETCH/DRAIN aborts the drain: rd_valid drops next cycle, and the block enters TRACE with pointers, entries and flags cleared.
- Config bytes are ignored outside IDLE.
- Reset mid-operation returns to the reset state immediately; any partially drained data is discarded.
- Pointer arithmetic is modulo TB_SIZE. entries is bounded to 0..TB_SIZE.

Decomposition:
- Shared package trace_pkg:
  - state enum tb_state_t {IDLE, TRACE, FETCH, DRAIN}
  - mode bit constant TB_MODE_LINEAR = 0
  - function tb_ptr_w = clog2(TB_SIZE)
- Sub-module tb_mem: simple dual-port RAM, TB_SIZE x (N*DATA_WIDTH). One write port, one registered read port, no reset. Inferable as block RAM.

Test Plan:
- Circular, no wrap: tracing=1, push 3 vectors with element j = 0x100*v+j (v=0..2), tracing=0.
  - rd_valid rises 2 cycles later; 24 elements emerge in order 0x000..0x007, 0x100..0x107, 0x200..0x207.
  - rd_last only on 0x207; wrapped=0; entries counts down 3->0.
- Circular wrap: TB_SIZE=8, push 10 vectors (v=0..9).
  - wrapped=1, entries=8; drain yields v=2..9 only.
- Linear overflow: configure mode=0x01, push 10 vectors.
  - overflow=1, entries=8; drain yields v=0..7.
- Backpressure: rd_ready toggles 1,0,0,1 during DRAIN.
  - rd_data and rd_last hold stable while rd_ready=0; no element is skipped or duplicated; total count is 8*N.
- Empty drain: tracing pulses 1->0 with no valid_in.
  - FSM returns to IDLE; rd_valid never asserts.
- Abort and reset: raise tracing after 5 drained elements.
  - rd_valid=0 next cycle, entries=0, and new captures start at address 0.
  - Separately, assert rst_n=0 mid-DRAIN: all outputs are 0 asynchronously.
